// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: owner encoding, default widths,
// and the saturating increment used by the optional statistics counters.
package vram_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWNER_NONE = 2'd0;
    localparam owner_t OWNER_REN  = 2'd1;
    localparam owner_t OWNER_MPU  = 2'd2;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int STATS_WIDTH    = 16;

    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] val);
        return (val == {STATS_WIDTH{1'b1}}) ? val : val + {{(STATS_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/vram_read_tag_pipe.sv
// Carries {valid, owner} for each read from its grant to the cycle its data returns.
module vram_read_tag_pipe
    import vram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   in_valid,
    input  owner_t in_owner,
    output logic   out_valid,
    output owner_t out_owner
);

    localparam int DEPTH = READ_LATENCY + 1;

    logic [DEPTH-1:0] valid_r;
    owner_t           owner_r [DEPTH];

    // Shift the tag one stage per cycle; reset drops every tag in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                owner_r[i] <= OWNER_NONE;
            end
        end else begin
            valid_r    <= {valid_r[DEPTH-2:0], in_valid};
            owner_r[0] <= in_valid ? in_owner : OWNER_NONE;
            for (int i = 1; i < DEPTH; i++) begin
                owner_r[i] <= owner_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_owner = owner_r[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Per-cycle arbiter sharing the VRAM port between renderer and MPU, with tagged read return.
// Optional statistics counters are built when VRAM_ARB_STATS_EN is defined.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int MPU_MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ren_req,
    input  logic                  ren_wr,
    input  logic [1:0]            ren_be,
    input  logic [ADDR_WIDTH-1:0] ren_addr,
    input  logic [DATA_WIDTH-1:0] ren_wdata,
    output logic                  ren_ack,
    output logic                  ren_rvalid,
    output logic [DATA_WIDTH-1:0] ren_rdata,
    input  logic                  mpu_req,
    input  logic                  mpu_wr,
    input  logic [1:0]            mpu_be,
    input  logic [ADDR_WIDTH-1:0] mpu_addr,
    input  logic [DATA_WIDTH-1:0] mpu_wdata,
    output logic                  mpu_ack,
    output logic                  mpu_rvalid,
    output logic [DATA_WIDTH-1:0] mpu_rdata,
    output logic                  vram_en,
    output logic                  vram_rd,
    output logic                  vram_wr,
    output logic [1:0]            vram_be,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_data_out,
    input  logic [DATA_WIDTH-1:0] vram_data_in
`ifdef VRAM_ARB_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [STATS_WIDTH-1:0] mpu_stall_cycles,
    output logic [STATS_WIDTH-1:0] ren_grants
`endif
);

    localparam logic [7:0] MAX_WAIT = 8'(MPU_MAX_WAIT);

    logic [7:0]            wait_cnt;
    logic                  ren_grant;
    logic                  mpu_grant;
    logic                  any_grant;
    logic                  sel_wr;
    logic [1:0]            sel_be;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  tag_valid;
    owner_t                tag_owner;
    logic [DATA_WIDTH-1:0] ren_rdata_r;
    logic [DATA_WIDTH-1:0] mpu_rdata_r;

    // Grant decision: a starved MPU overrides the renderer's default priority.
    always_comb begin
        ren_grant = 1'b0;
        mpu_grant = 1'b0;
        if (reset) begin
            ren_grant = 1'b0;
        end else if (mpu_req && (wait_cnt == MAX_WAIT)) begin
            mpu_grant = 1'b1;
        end else if (ren_req) begin
            ren_grant = 1'b1;
        end else if (mpu_req) begin
            mpu_grant = 1'b1;
        end else begin
            mpu_grant = 1'b0;
        end
    end

    // Command fields of the winning requester.
    always_comb begin
        sel_wr    = mpu_wr;
        sel_be    = mpu_be;
        sel_addr  = mpu_addr;
        sel_wdata = mpu_wdata;
        if (ren_grant) begin
            sel_wr    = ren_wr;
            sel_be    = ren_be;
            sel_addr  = ren_addr;
            sel_wdata = ren_wdata;
        end else begin
            sel_wr    = mpu_wr;
        end
    end

    assign any_grant = ren_grant | mpu_grant;
    assign ren_ack   = ren_grant;
    assign mpu_ack   = mpu_grant;

    // Register the granted command onto the VRAM bus and track MPU starvation.
    always_ff @(posedge clk) begin
        if (reset) begin
            vram_en       <= 1'b0;
            vram_rd       <= 1'b0;
            vram_wr       <= 1'b0;
            vram_be       <= 2'b00;
            vram_addr     <= '0;
            vram_data_out <= '0;
            wait_cnt      <= 8'd0;
        end else begin
            vram_en <= any_grant;
            vram_rd <= any_grant & ~sel_wr;
            vram_wr <= any_grant & sel_wr;
            if (any_grant) begin
                vram_be   <= sel_be;
                vram_addr <= sel_addr;
                if (sel_wr) begin
                    vram_data_out <= sel_wdata;
                end
            end
            if (mpu_req && !mpu_grant) begin
                wait_cnt <= (wait_cnt >= MAX_WAIT) ? MAX_WAIT : wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

    vram_read_tag_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (any_grant & ~sel_wr),
        .in_owner  (ren_grant ? OWNER_REN : OWNER_MPU),
        .out_valid (tag_valid),
        .out_owner (tag_owner)
    );

    // rvalid coincides with vram_data_in; rdata passes it through, then holds it.
    assign ren_rvalid = ~reset & tag_valid & (tag_owner == OWNER_REN);
    assign mpu_rvalid = ~reset & tag_valid & (tag_owner == OWNER_MPU);
    assign ren_rdata  = ren_rvalid ? vram_data_in : ren_rdata_r;
    assign mpu_rdata  = mpu_rvalid ? vram_data_in : mpu_rdata_r;

    // Capture returned read data for the owning requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            ren_rdata_r <= '0;
            mpu_rdata_r <= '0;
        end else begin
            if (ren_rvalid) begin
                ren_rdata_r <= vram_data_in;
            end
            if (mpu_rvalid) begin
                mpu_rdata_r <= vram_data_in;
            end
        end
    end

`ifdef VRAM_ARB_STATS_EN
    // Saturating usage counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            mpu_stall_cycles <= '0;
            ren_grants       <= '0;
        end else begin
            if (mpu_req && !mpu_grant) begin
                mpu_stall_cycles <= sat_inc(mpu_stall_cycles);
            end
            if (ren_grant) begin
                ren_grants <= sat_inc(ren_grants);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus queues expected grants, commands, read
// returns and level checks; a negedge monitor pops and compares them.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    typedef struct {int cyc; owner_t own;} gnt_t;
    typedef struct {int cyc; logic wr; logic [1:0] be; logic [15:0] addr; logic [15:0] data;} cmd_t;
    typedef struct {int cyc; logic [15:0] data;} rd_t;
    typedef struct {int cyc; int id; logic [31:0] exp;} lvl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ren_req = 1'b0, ren_wr = 1'b0, mpu_req = 1'b0, mpu_wr = 1'b0;
    logic [1:0]  ren_be = 2'b00, mpu_be = 2'b00;
    logic [15:0] ren_addr = 16'h0, ren_wdata = 16'h0, mpu_addr = 16'h0, mpu_wdata = 16'h0;
    logic        ren_ack, ren_rvalid, mpu_ack, mpu_rvalid;
    logic [15:0] ren_rdata, mpu_rdata;
    logic        vram_en, vram_rd, vram_wr;
    logic [1:0]  vram_be;
    logic [15:0] vram_addr, vram_data_out;
    logic [15:0] vram_data_in = 16'h0;
`ifdef VRAM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] mpu_stall_cycles, ren_grants;
`endif

    gnt_t gq[$];
    cmd_t cq[$];
    rd_t  rrq[$];
    rd_t  rmq[$];
    lvl_t lq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   idle_cnt = 0;
    bit   window = 1'b0;
    bit   done = 1'b0;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .ren_req(ren_req), .ren_wr(ren_wr), .ren_be(ren_be), .ren_addr(ren_addr),
        .ren_wdata(ren_wdata), .ren_ack(ren_ack), .ren_rvalid(ren_rvalid), .ren_rdata(ren_rdata),
        .mpu_req(mpu_req), .mpu_wr(mpu_wr), .mpu_be(mpu_be), .mpu_addr(mpu_addr),
        .mpu_wdata(mpu_wdata), .mpu_ack(mpu_ack), .mpu_rvalid(mpu_rvalid), .mpu_rdata(mpu_rdata),
        .vram_en(vram_en), .vram_rd(vram_rd), .vram_wr(vram_wr), .vram_be(vram_be),
        .vram_addr(vram_addr), .vram_data_out(vram_data_out), .vram_data_in(vram_data_in)
`ifdef VRAM_ARB_STATS_EN
        , .stats_clr(stats_clr), .mpu_stall_cycles(mpu_stall_cycles), .ren_grants(ren_grants)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rd_val(input logic [15:0] a);
        case (a)
            16'h0100: return 16'hBEEF;
            16'h0010: return 16'hAAAA;
            16'h0020: return 16'h5555;
            default:  return 16'hDEAD;
        endcase
    endfunction

    // VRAM model with one cycle of read latency
    always @(posedge clk) begin
        if (vram_en && vram_rd) vram_data_in <= rd_val(vram_addr);
    end

    function automatic logic [31:0] act_of(input int id);
        case (id)
            0:  return {31'd0, ren_ack};
            1:  return {31'd0, ren_rvalid};
            2:  return {16'd0, ren_rdata};
            3:  return {31'd0, mpu_ack};
            4:  return {31'd0, mpu_rvalid};
            5:  return {16'd0, mpu_rdata};
            6:  return {31'd0, vram_en};
            7:  return {31'd0, vram_rd};
            8:  return {31'd0, vram_wr};
            9:  return {30'd0, vram_be};
            10: return {16'd0, vram_addr};
            11: return {16'd0, vram_data_out};
            12: return {24'd0, dut.wait_cnt};
`ifdef VRAM_ARB_STATS_EN
            13: return {16'd0, mpu_stall_cycles};
            14: return {16'd0, ren_grants};
`endif
            15: return idle_cnt;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic string name_of(input int id);
        case (id)
            0: return "ren_ack";     1: return "ren_rvalid";  2: return "ren_rdata";
            3: return "mpu_ack";     4: return "mpu_rvalid";  5: return "mpu_rdata";
            6: return "vram_en";     7: return "vram_rd";     8: return "vram_wr";
            9: return "vram_be";     10: return "vram_addr";  11: return "vram_data_out";
            12: return "wait_cnt";   13: return "mpu_stall_cycles";
            14: return "ren_grants"; 15: return "idle_cycles";
            default: return "unknown";
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops and compares every expectation the DUT presents
    always @(negedge clk) begin
        if (window && !ren_ack && !mpu_ack) idle_cnt++;
        while (lq.size() > 0 && lq[0].cyc <= cyc) begin
            lvl_t l;
            l = lq.pop_front();
            chk(name_of(l.id), act_of(l.id), l.exp);
        end
        if (ren_ack || mpu_ack) begin
            gnt_t g;
            chk("single_grant", {31'd0, ren_ack & mpu_ack}, 32'd0);
            if (gq.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
            else begin
                g = gq.pop_front();
                chk("grant_owner", {30'd0, (ren_ack ? OWNER_REN : OWNER_MPU)}, {30'd0, g.own});
                chk("grant_cycle", cyc, g.cyc);
            end
        end
        if (vram_en) begin
            cmd_t c;
            if (cq.size() == 0) chk("unexpected_cmd", 32'd1, 32'd0);
            else begin
                c = cq.pop_front();
                chk("cmd_cycle", cyc, c.cyc);
                chk("cmd_wr", {31'd0, vram_wr}, {31'd0, c.wr});
                chk("cmd_rd", {31'd0, vram_rd}, {31'd0, ~c.wr});
                chk("cmd_be", {30'd0, vram_be}, {30'd0, c.be});
                chk("cmd_addr", {16'd0, vram_addr}, {16'd0, c.addr});
                if (c.wr) chk("cmd_data", {16'd0, vram_data_out}, {16'd0, c.data});
            end
        end
        if (ren_rvalid) begin
            rd_t r;
            if (rrq.size() == 0) chk("unexpected_ren_rvalid", 32'd1, 32'd0);
            else begin
                r = rrq.pop_front();
                chk("ren_rvalid_cycle", cyc, r.cyc);
                chk("ren_rdata_ret", {16'd0, ren_rdata}, {16'd0, r.data});
            end
        end
        if (mpu_rvalid) begin
            rd_t r;
            if (rmq.size() == 0) chk("unexpected_mpu_rvalid", 32'd1, 32'd0);
            else begin
                r = rmq.pop_front();
                chk("mpu_rvalid_cycle", cyc, r.cyc);
                chk("mpu_rdata_ret", {16'd0, mpu_rdata}, {16'd0, r.data});
            end
        end
        if (done) begin
            chk("gnt_queue_left", gq.size(), 32'd0);
            chk("cmd_queue_left", cq.size(), 32'd0);
            chk("ren_rd_queue_left", rrq.size(), 32'd0);
            chk("mpu_rd_queue_left", rmq.size(), 32'd0);
            chk("lvl_queue_left", lq.size(), 32'd0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input int c, input owner_t o);
        gq.push_back('{cyc: c, own: o});
    endtask

    task automatic push_cmd(input int c, input logic w, input logic [1:0] b,
                            input logic [15:0] a, input logic [15:0] d);
        cq.push_back('{cyc: c, wr: w, be: b, addr: a, data: d});
    endtask

    task automatic push_lvl(input int c, input int id, input logic [31:0] e);
        lq.push_back('{cyc: c, id: id, exp: e});
    endtask

    task automatic push_zero(input int c);
        for (int i = 0; i < 12; i++) push_lvl(c, i, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        tick(); tick();
        push_zero(cyc);
        tick();
        reset = 1'b0;
        push_zero(cyc);
        tick();

        // Renderer-only read
        c = cyc;
        ren_req = 1'b1; ren_wr = 1'b0; ren_be = 2'b11; ren_addr = 16'h0100;
        push_gnt(c, OWNER_REN);
        push_cmd(c + 1, 1'b0, 2'b11, 16'h0100, 16'h0);
        rrq.push_back('{cyc: c + 2, data: 16'hBEEF});
        tick(); ren_req = 1'b0;
        repeat (4) tick();

        // MPU-only write
        c = cyc;
        mpu_req = 1'b1; mpu_wr = 1'b1; mpu_be = 2'b01; mpu_addr = 16'h0020; mpu_wdata = 16'h1234;
        push_gnt(c, OWNER_MPU);
        push_cmd(c + 1, 1'b1, 2'b01, 16'h0020, 16'h1234);
        tick(); mpu_req = 1'b0;
        repeat (4) tick();

        // Both requesting continuously: 8 renderer grants then one MPU grant
        c = cyc;
        ren_req = 1'b1; ren_wr = 1'b1; ren_be = 2'b11; ren_addr = 16'h0300; ren_wdata = 16'h1111;
        mpu_req = 1'b1; mpu_wr = 1'b1; mpu_be = 2'b10; mpu_addr = 16'h0400; mpu_wdata = 16'h2222;
        window = 1'b1;
        for (int i = 0; i < 27; i++) begin
            if (i % 9 == 8) begin
                push_gnt(c + i, OWNER_MPU);
                push_cmd(c + i + 1, 1'b1, 2'b10, 16'h0400, 16'h2222);
            end else begin
                push_gnt(c + i, OWNER_REN);
                push_cmd(c + i + 1, 1'b1, 2'b11, 16'h0300, 16'h1111);
            end
        end
        repeat (27) tick();
        ren_req = 1'b0; mpu_req = 1'b0; window = 1'b0;
        push_lvl(cyc, 15, 32'd0);
        repeat (3) tick();

        // Interleaved reads: renderer 0x10, then MPU 0x20
        c = cyc;
        ren_req = 1'b1; ren_wr = 1'b0; ren_be = 2'b11; ren_addr = 16'h0010;
        mpu_req = 1'b1; mpu_wr = 1'b0; mpu_be = 2'b11; mpu_addr = 16'h0020;
        push_gnt(c, OWNER_REN);
        push_gnt(c + 1, OWNER_MPU);
        push_cmd(c + 1, 1'b0, 2'b11, 16'h0010, 16'h0);
        push_cmd(c + 2, 1'b0, 2'b11, 16'h0020, 16'h0);
        rrq.push_back('{cyc: c + 2, data: 16'hAAAA});
        rmq.push_back('{cyc: c + 3, data: 16'h5555});
        tick(); ren_req = 1'b0;
        tick(); mpu_req = 1'b0;
        repeat (4) tick();
        push_lvl(cyc, 2, 32'h0000_AAAA);
        push_lvl(cyc, 5, 32'h0000_5555);
        tick();

        // Reset one cycle after a read grant, with the MPU waiting
        c = cyc;
        ren_req = 1'b1; ren_wr = 1'b0; ren_be = 2'b11; ren_addr = 16'h0500;
        mpu_req = 1'b1; mpu_wr = 1'b1; mpu_be = 2'b11; mpu_addr = 16'h0600; mpu_wdata = 16'h3333;
        push_gnt(c, OWNER_REN);
        push_cmd(c + 1, 1'b0, 2'b11, 16'h0500, 16'h0);
        tick(); ren_req = 1'b0; reset = 1'b1;
        tick(); reset = 1'b0; mpu_req = 1'b0;
        push_zero(c + 2);
        push_lvl(c + 2, 12, 32'd0);
        repeat (4) tick();

`ifdef VRAM_ARB_STATS_EN
        stats_clr = 1'b1;
        tick(); stats_clr = 1'b0;
        c = cyc;
        ren_req = 1'b1; ren_wr = 1'b1; ren_be = 2'b11; ren_addr = 16'h0700; ren_wdata = 16'h7777;
        mpu_req = 1'b1; mpu_wr = 1'b1; mpu_be = 2'b11; mpu_addr = 16'h0800; mpu_wdata = 16'h8888;
        for (int i = 0; i < 5; i++) begin
            push_gnt(c + i, OWNER_REN);
            push_cmd(c + i + 1, 1'b1, 2'b11, 16'h0700, 16'h7777);
        end
        repeat (5) tick();
        ren_req = 1'b0; mpu_req = 1'b0;
        push_lvl(c + 5, 13, 32'd5);
        push_lvl(c + 5, 14, 32'd5);
        tick();
        ren_req = 1'b1; mpu_req = 1'b1; stats_clr = 1'b1;
        push_gnt(c + 6, OWNER_REN);
        push_cmd(c + 7, 1'b1, 2'b11, 16'h0700, 16'h7777);
        tick();
        ren_req = 1'b0; mpu_req = 1'b0; stats_clr = 1'b0;
        push_lvl(c + 7, 13, 32'd0);
        push_lvl(c + 7, 14, 32'd0);
        repeat (3) tick();
`endif

        done = 1'b1;
    end

endmodule
